lu_sweep_checker: RTL and testbench

Initiator/checker for the team's 1-bit selectable logic unit (operands a/b, 3-bit select, negate_b, 1-bit result). On start it drives every operation/negate/operand combination into the unit and samples the returned result. It assembles a 4-entry truth table per (op, negate) pair and compares each table against the golden table. It sits beside the logic unit in the Guia 7 testbench/top and reports per-pair pass flags.

---
 rtl/lu_pkg.sv | 32 +++
 rtl/lu_golden.sv | 37 +++
 rtl/lu_sweep_checker.sv | 155 +++++++++++++++
 tb/tb_lu_sweep_checker.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lu_pkg.sv
// Shared definitions for the logic-unit sweep checker: op codes, FSM states, table width.
// Defining LU_SWEEP_RSVD_EN extends the sweep to include the reserved op 3'b111.
package lu_pkg;

    localparam logic [2:0] LU_NOT  = 3'd0;
    localparam logic [2:0] LU_AND  = 3'd1;
    localparam logic [2:0] LU_NAND = 3'd2;
    localparam logic [2:0] LU_OR   = 3'd3;
    localparam logic [2:0] LU_NOR  = 3'd4;
    localparam logic [2:0] LU_XOR  = 3'd5;
    localparam logic [2:0] LU_XNOR = 3'd6;
    localparam logic [2:0] LU_RSVD = 3'd7;

    localparam int TT_W = 4;

`ifdef LU_SWEEP_RSVD_EN
    localparam logic [2:0]  LU_LAST_OP   = LU_RSVD;
    localparam logic [15:0] LU_PASS_BITS = 16'hFFFF;
`else
    localparam logic [2:0]  LU_LAST_OP   = LU_XNOR;
    localparam logic [15:0] LU_PASS_BITS = 16'h3FFF;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_SAMPLE,
        ST_REPORT,
        ST_FINISH
    } state_t;

endpackage

// File: rtl/lu_golden.sv
// Expected 4-entry truth table of the logic unit for a given (op, negate_b) pair.
// Bit idx of tt is the result for {a,b} = idx.
module lu_golden
    import lu_pkg::*;
(
    input  logic [2:0]      op,
    input  logic            neg,
    output logic [TT_W-1:0] tt
);

    logic [1:0] ix;
    logic       a;
    logic       bn;

    always_comb begin
        tt = '0;
        ix = '0;
        a  = 1'b0;
        bn = 1'b0;
        for (int i = 0; i < TT_W; i++) begin
            ix = 2'(i);
            a  = ix[1];
            bn = ix[0] ^ neg;
            case (op)
                LU_NOT:  tt[i] = ~a;
                LU_AND:  tt[i] = a & bn;
                LU_NAND: tt[i] = ~(a & bn);
                LU_OR:   tt[i] = a | bn;
                LU_NOR:  tt[i] = ~(a | bn);
                LU_XOR:  tt[i] = a ^ bn;
                LU_XNOR: tt[i] = ~(a ^ bn);
                default: tt[i] = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/lu_sweep_checker.sv
// Drives every (op, negate_b, a, b) vector into the logic unit, assembles truth tables
// and compares each against lu_golden. LU_SWEEP_RSVD_EN adds the reserved op to the sweep.
module lu_sweep_checker
    import lu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic        lu_a,
    output logic        lu_b,
    output logic [2:0]  lu_select,
    output logic        lu_negate_b,
    input  logic        lu_result,
    output logic        busy,
    output logic        tt_valid,
    output logic [2:0]  tt_op,
    output logic        tt_neg,
    output logic [3:0]  tt_out,
    output logic [15:0] pass_mask,
    output logic        error,
    output logic        done
);

    state_t          state, state_nxt;
    logic [2:0]      op;
    logic            neg;
    logic [1:0]      idx;
    logic [3:0]      cnt;
    logic [TT_W-1:0] tt_cur;
    logic [TT_W-1:0] golden;
    logic [TT_W-1:0] tt_out_q;
    logic [2:0]      tt_op_q;
    logic            tt_neg_q;
    logic [15:0]     pass_q;
    logic            hold_done;
    logic            last_pair;

    assign hold_done = (cnt == 4'(SETTLE_CYCLES - 1));
    assign last_pair = (op == LU_LAST_OP) && neg;

    lu_golden u_golden (
        .op  (op),
        .neg (neg),
        .tt  (golden)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        busy        = 1'b0;
        tt_valid    = 1'b0;
        done        = 1'b0;
        lu_a        = 1'b0;
        lu_b        = 1'b0;
        lu_select   = '0;
        lu_negate_b = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                busy = 1'b1;
                if (abort)          state_nxt = ST_IDLE;
                else if (hold_done) state_nxt = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                busy = 1'b1;
                if (abort)              state_nxt = ST_IDLE;
                else if (idx == 2'd3)   state_nxt = ST_REPORT;
                else                    state_nxt = ST_HOLD;
            end
            ST_REPORT: begin
                busy = 1'b1;
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    tt_valid  = 1'b1;
                    state_nxt = last_pair ? ST_FINISH : ST_HOLD;
                end
            end
            ST_FINISH: begin
                done      = !abort;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Vectors are presented only while a table is being built or reported.
        if (busy) begin
            lu_a        = idx[1];
            lu_b        = idx[0];
            lu_select   = op;
            lu_negate_b = neg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op       <= '0;
            neg      <= 1'b0;
            idx      <= '0;
            cnt      <= '0;
            tt_cur   <= '0;
            tt_out_q <= '0;
            tt_op_q  <= '0;
            tt_neg_q <= 1'b0;
            pass_q   <= '0;
            error    <= 1'b0;
        end else if (!abort) begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op     <= '0;
                        neg    <= 1'b0;
                        idx    <= '0;
                        cnt    <= '0;
                        pass_q <= '0;
                        error  <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    cnt <= hold_done ? 4'd0 : cnt + 4'd1;
                end
                ST_SAMPLE: begin
                    tt_cur[idx] <= lu_result;
                    if (idx != 2'd3) idx <= idx + 2'd1;
                end
                ST_REPORT: begin
                    pass_q[{op, neg}] <= (tt_cur == golden);
                    error             <= error | (tt_cur != golden);
                    tt_out_q          <= tt_cur;
                    tt_op_q           <= op;
                    tt_neg_q          <= neg;
                    idx               <= '0;
                    neg               <= ~neg;
                    if (neg) op <= op + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Table fields are live during the report cycle and hold afterwards.
    assign tt_out    = tt_valid ? tt_cur : tt_out_q;
    assign tt_op     = tt_valid ? op     : tt_op_q;
    assign tt_neg    = tt_valid ? neg    : tt_neg_q;
    assign pass_mask = pass_q & LU_PASS_BITS;

endmodule

// File: tb/tb_lu_sweep_checker.sv
// Bench for lu_sweep_checker: behavioural logic unit with injectable faults plus a table-level reference.
module tb_lu_sweep_checker;

    localparam int SETTLE = 1;
`ifdef LU_SWEEP_RSVD_EN
    localparam int NPAIRS = 16;
`else
    localparam int NPAIRS = 14;
`endif
    localparam int SWEEP_LAT = NPAIRS * 4 * (SETTLE + 1) + NPAIRS + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        lu_a, lu_b, lu_negate_b, lu_result;
    logic [2:0]  lu_select;
    logic        busy, tt_valid, tt_neg, error, done;
    logic [2:0]  tt_op;
    logic [3:0]  tt_out;
    logic [15:0] pass_mask;

    int          nvec = 0;
    int          nerr = 0;
    int          cyc  = 0;
    logic [3:0]  fault [16];
    logic        and_stuck = 1'b0;
    logic [7:0]  rep_q [$];
    logic [3:0]  unit_tt;

    lu_sweep_checker #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .lu_a        (lu_a),
        .lu_b        (lu_b),
        .lu_select   (lu_select),
        .lu_negate_b (lu_negate_b),
        .lu_result   (lu_result),
        .busy        (busy),
        .tt_valid    (tt_valid),
        .tt_op       (tt_op),
        .tt_neg      (tt_neg),
        .tt_out      (tt_out),
        .pass_mask   (pass_mask),
        .error       (error),
        .done        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (tt_valid === 1'b1) rep_q.push_back({tt_op, tt_neg, tt_out});

    // Truth table from the logic unit's definition, using integer arithmetic.
    function automatic logic [3:0] spec_tt(input int op, input int neg);
        logic [3:0] t;
        int a, b, r;
        t = '0;
        for (int i = 0; i < 4; i++) begin
            a = (i >> 1) & 1;
            b = (i & 1) ^ neg;
            case (op)
                0: r = 1 - a;
                1: r = a & b;
                2: r = 1 - (a & b);
                3: r = a | b;
                4: r = 1 - (a | b);
                5: r = a ^ b;
                6: r = 1 - (a ^ b);
                default: r = 0;
            endcase
            t[i] = r[0];
        end
        return t;
    endfunction

    // Table the attached (possibly faulty) unit actually produces for pair p = {op,neg}.
    function automatic logic [3:0] unit_table(input int p);
        if (and_stuck && (p >> 1) == 1) return 4'b0000;
        return spec_tt(p >> 1, p & 1) ^ fault[p];
    endfunction

    function automatic logic [15:0] exp_pass_mask();
        logic [15:0] m;
        m = '0;
        for (int p = 0; p < NPAIRS; p++)
            if (unit_table(p) == spec_tt(p >> 1, p & 1)) m[p] = 1'b1;
        return m;
    endfunction

    always_comb begin
        unit_tt = spec_tt(int'(lu_select), int'(lu_negate_b)) ^ fault[{lu_select, lu_negate_b}];
        if (and_stuck && lu_select == 3'd1) unit_tt = 4'b0000;
    end
    assign lu_result = unit_tt[{lu_a, lu_b}];

    task automatic wait_done(input int s, output int lat, output bit ok);
        ok  = 1'b0;
        lat = -1;
        for (int i = 0; i < 3000; i++) begin
            if (done === 1'b1) begin
                ok  = 1'b1;
                lat = cyc - s;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            nvec++;
            nerr++;
            $display("FAIL done_timeout: no done within 3000 cycles, required one");
        end
    endtask

    task automatic run_sweep(output int lat, output bit ok);
        int s;
        rep_q.delete();
        @(negedge clk);
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        wait_done(s, lat, ok);
    endtask

    task automatic check_sweep(input string name, input int lat);
        logic       exp_err;
        logic [7:0] e;
        exp_err = 1'b0;
        for (int p = 0; p < NPAIRS; p++)
            if (unit_table(p) != spec_tt(p >> 1, p & 1)) exp_err = 1'b1;
        nvec++;
        if (lat !== SWEEP_LAT) begin
            nerr++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, SWEEP_LAT);
        end
        nvec++;
        if (pass_mask !== exp_pass_mask()) begin
            nerr++;
            $display("FAIL %s pass_mask: got %h required %h", name, pass_mask, exp_pass_mask());
        end
        nvec++;
        if (error !== exp_err) begin
            nerr++;
            $display("FAIL %s error: got %b required %b", name, error, exp_err);
        end
        nvec++;
        if (busy !== 1'b0) begin
            nerr++;
            $display("FAIL %s busy_at_done: got %b required 0", name, busy);
        end
        nvec++;
        if (rep_q.size() != NPAIRS) begin
            nerr++;
            $display("FAIL %s table_count: got %0d required %0d", name, rep_q.size(), NPAIRS);
        end
        for (int p = 0; p < NPAIRS && p < rep_q.size(); p++) begin
            e = {p[3:0], unit_table(p)};
            nvec++;
            if (rep_q[p] !== e) begin
                nerr++;
                $display("FAIL %s table[%0d]: got %h required %h", name, p, rep_q[p], e);
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        nvec++;
        if ({busy, tt_valid, done, error, lu_a, lu_b, lu_select, lu_negate_b,
             tt_op, tt_neg, tt_out, pass_mask} !== 34'd0) begin
            nerr++;
            $display("FAIL power_on_reset: got busy=%b pm=%h tt=%h, required all zero", busy, pass_mask, tt_out);
        end
        reset = 1'b0;
    endtask

    task automatic test_clean_sweep;
        int lat;
        bit ok;
        logic [7:0] r;
        run_sweep(lat, ok);
        check_sweep("clean", lat);
        if (rep_q.size() >= 4) begin
            r = rep_q[0];
            nvec++;
            if (r !== 8'b0000_0011) begin
                nerr++;
                $display("FAIL first_table: got %h required 03", r);
            end
            r = rep_q[2];
            nvec++;
            if (r[3:0] !== 4'b1000) begin
                nerr++;
                $display("FAIL and_neg0: got %b required 1000", r[3:0]);
            end
            r = rep_q[3];
            nvec++;
            if (r[3:0] !== 4'b0100) begin
                nerr++;
                $display("FAIL and_neg1: got %b required 0100", r[3:0]);
            end
        end
        repeat (3) @(negedge clk);
        nvec++;
        if (tt_valid !== 1'b0 || tt_out !== unit_table(NPAIRS - 1)) begin
            nerr++;
            $display("FAIL tt_hold: got valid=%b tt=%b required valid=0 tt=%b",
                     tt_valid, tt_out, unit_table(NPAIRS - 1));
        end
    endtask

    task automatic test_reset_mid_sweep;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (18) @(negedge clk);
        nvec++;
        if (pass_mask !== 16'h0003 || lu_select !== 3'd1 || busy !== 1'b1) begin
            nerr++;
            $display("FAIL pre_reset: got pm=%h sel=%0d busy=%b required 0003 1 1", pass_mask, lu_select, busy);
        end
        reset = 1'b1;
        #1;
        nvec++;
        if ({busy, tt_valid, done, error, lu_a, lu_b, lu_select, lu_negate_b,
             tt_op, tt_neg, tt_out, pass_mask} !== 34'd0) begin
            nerr++;
            $display("FAIL mid_reset: got busy=%b sel=%0d pm=%h tt=%h, required all zero",
                     busy, lu_select, pass_mask, tt_out);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        nvec++;
        if (busy !== 1'b0 || lu_select !== 3'd0) begin
            nerr++;
            $display("FAIL post_reset_idle: got busy=%b sel=%0d required 0 0", busy, lu_select);
        end
    endtask

    task automatic test_random_faults;
        int lat;
        bit ok;
        for (int it = 0; it < 4; it++) begin
            for (int p = 0; p < 16; p++)
                fault[p] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            run_sweep(lat, ok);
            check_sweep($sformatf("random%0d", it), lat);
        end
        for (int p = 0; p < 16; p++) fault[p] = 4'd0;
    endtask

    task automatic test_and_stuck;
        int lat;
        bit ok;
        and_stuck = 1'b1;
        run_sweep(lat, ok);
        check_sweep("and_stuck", lat);
        nvec++;
        if (pass_mask[3:2] !== 2'b00 || error !== 1'b1) begin
            nerr++;
            $display("FAIL and_stuck_flags: got pm=%h err=%b required bits3:2=0 err=1", pass_mask, error);
        end
        and_stuck = 1'b0;
    endtask

    task automatic test_abort;
        int  s;
        bit  seen_done;
        rep_q.delete();
        @(negedge clk);
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (cyc == s + 27) break;
        end
        nvec++;
        if (tt_valid !== 1'b1 || tt_op !== 3'd1 || tt_neg !== 1'b0) begin
            nerr++;
            $display("FAIL abort_report_cycle: got valid=%b op=%0d neg=%b required 1 1 0", tt_valid, tt_op, tt_neg);
        end
        abort = 1'b1;
        #1;
        nvec++;
        if (tt_valid !== 1'b0) begin
            nerr++;
            $display("FAIL abort_tt_valid: got %b required 0", tt_valid);
        end
        @(negedge clk);
        @(negedge clk);
        abort = 1'b0;
        nvec++;
        if (busy !== 1'b0) begin
            nerr++;
            $display("FAIL abort_busy: got %b required 0", busy);
        end
        seen_done = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        nvec++;
        if (seen_done || rep_q.size() != 2) begin
            nerr++;
            $display("FAIL abort_quiet: got done=%b tables=%0d required 0 2", seen_done, rep_q.size());
        end
        nvec++;
        if (pass_mask !== 16'h0003 || error !== 1'b0) begin
            nerr++;
            $display("FAIL abort_partial: got pm=%h err=%b required 0003 0", pass_mask, error);
        end
    endtask

    task automatic test_back_to_back;
        int s, lat;
        bit ok, seen_done;
        rep_q.delete();
        @(negedge clk);
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(s, lat, ok);
        check_sweep("restart_busy", lat);
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        nvec++;
        if (busy !== 1'b0) begin
            nerr++;
            $display("FAIL start_abort_busy: got %b required 0", busy);
        end
        seen_done = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
        end
        nvec++;
        if (seen_done || pass_mask !== exp_pass_mask()) begin
            nerr++;
            $display("FAIL start_abort_idle: got activity=%b pm=%h required 0 %h", seen_done, pass_mask, exp_pass_mask());
        end
    endtask

    initial begin
        for (int p = 0; p < 16; p++) fault[p] = 4'd0;
        test_reset();
        test_clean_sweep();
        test_reset_mid_sweep();
        test_random_faults();
        test_and_stuck();
        test_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
